key_event_fifo: RTL and testbench

//  Downstream of the keypad scan decoder. Takes the decoder's 5-bit key code and a
//  key-hit strobe (OR of the column lines). Debounces press and release over whole scan

---
 rtl/key_event_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_key_event_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// Keypad event path: debounces key presses over whole scan windows and queues one
// 5-bit code per accepted press. Define KEY_REPEAT_EN to enable auto-repeat while held.
module key_event_fifo #(
    parameter int unsigned SCAN_LEN      = 4,
    parameter int unsigned DB_FRAMES     = 3,
    parameter int unsigned DEPTH_LOG2    = 3,
    parameter int unsigned REPEAT_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_hit,
    input  logic [4:0]            key_code,
    output logic                  rd_valid,
    output logic [4:0]            rd_data,
    input  logic                  rd_ack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  key_down
);

    localparam int unsigned CODE_W = 5;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned WIN_W  = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam int unsigned DB_W   = $clog2(DB_FRAMES + 1);

    if (SCAN_LEN < 1 || DB_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_cfg_check
        $error("key_event_fifo: SCAN_LEN, DB_FRAMES and REPEAT_FRAMES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

    state_e                  state_q, state_d;
    logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
    logic                    hit_seen_q, hit_seen_d;
    logic [DB_W-1:0]         db_q, db_d;
    logic [CODE_W-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    rd_valid_q, overflow_q, overflow_d, key_down_q;

    logic                    win_end, frame_down, db_hit;
    logic                    ev_push, push, pop, full, wr, drop;
    logic [CODE_W-1:0]       push_data;

    // Scan window framing: a frame is "down" if key_hit was seen anywhere in it.
    always_comb begin
        win_end    = (win_cnt_q == WIN_W'(SCAN_LEN - 1));
        frame_down = hit_seen_q | key_hit;
        win_cnt_d  = win_end ? '0 : win_cnt_q + WIN_W'(1);
        hit_seen_d = win_end ? 1'b0 : (hit_seen_q | key_hit);
        db_hit     = ((db_q + DB_W'(1)) == DB_W'(DB_FRAMES));
    end

    // Debounce FSM, advanced only at window-end edges.
    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        ev_push = 1'b0;
        if (win_end) begin
            unique case (state_q)
                IDLE: if (frame_down) begin
                    if (DB_FRAMES == 1) begin
                        ev_push = 1'b1;
                        state_d = HELD;
                    end else begin
                        state_d = PRESS_DB;
                        db_d    = DB_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (!frame_down) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else if (db_hit) begin
                        ev_push = 1'b1;
                        state_d = HELD;
                        db_d    = '0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                HELD: if (!frame_down) begin
                    if (DB_FRAMES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASE_DB;
                        db_d    = DB_W'(1);
                    end
                end
                RELEASE_DB: begin
                    if (frame_down) begin
                        state_d = HELD;
                        db_d    = '0;
                    end else if (db_hit) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    db_d    = '0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 1);

    logic [REP_W-1:0]  rep_q, rep_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              rep_push;

    // Auto-repeat: counts down-frames while HELD, re-pushing the code latched at acceptance.
    always_comb begin
        rep_d    = '0;
        code_d   = code_q;
        rep_push = 1'b0;
        if (ev_push) code_d = key_code;
        if (state_q == HELD) begin
            rep_d = rep_q;
            if (win_end && !frame_down) begin
                rep_d = '0;
            end else if (win_end) begin
                if ((rep_q + REP_W'(1)) == REP_W'(REPEAT_FRAMES)) begin
                    rep_push = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
        end
        push      = ev_push | rep_push;
        push_data = rep_push ? code_q : key_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q  <= '0;
            code_q <= '0;
        end else begin
            rep_q  <= rep_d;
            code_q <= code_d;
        end
    end
`else
    always_comb begin
        push      = ev_push;
        push_data = key_code;
    end
`endif

    // FIFO control: a pop frees the slot, so push+pop on a full FIFO never drops.
    always_comb begin
        pop        = rd_valid_q & rd_ack;
        full       = (count_q == CNT_W'(DEPTH));
        wr         = push & (~full | pop);
        drop       = push & full & ~pop;
        count_d    = count_q + CNT_W'(wr) - CNT_W'(pop);
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            hit_seen_q <= 1'b0;
            db_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            key_down_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            hit_seen_q <= hit_seen_d;
            db_q       <= db_d;
            count_q    <= count_d;
            rd_valid_q <= (count_d != '0);
            overflow_q <= overflow_d;
            key_down_q <= (state_d == HELD) || (state_d == RELEASE_DB);
            if (wr) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign key_down = key_down_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: directed scenarios plus randomized key activity, all checked
// every cycle against a frame-level behavioural model (honours KEY_REPEAT_EN).
module tb_key_event_fifo;

    localparam int SCAN  = 4;
    localparam int DB    = 3;
    localparam int DEPTH = 8;
    localparam int REP   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_hit = 1'b0;
    logic [4:0] key_code = '0;
    logic       rd_ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       rd_valid, overflow, key_down;
    logic [4:0] rd_data;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    key_event_fifo #(.REPEAT_FRAMES(REP)) dut (
        .clk(clk), .rst_n(rst_n), .key_hit(key_hit), .key_code(key_code),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ack(rd_ack), .count(count),
        .overflow(overflow), .ovf_clr(ovf_clr), .key_down(key_down)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: debounced level plus a streak of frames disagreeing with it.
    int         m_win, m_streak, m_rep;
    bit         m_seen, m_level, m_ovf;
    logic [4:0] m_code;
    logic [4:0] q[$];

    function automatic void m_reset();
        m_win = 0; m_streak = 0; m_rep = 0;
        m_seen = 0; m_level = 0; m_ovf = 0; m_code = '0;
        q.delete();
    endfunction

    task automatic m_step(input bit hit, input logic [4:0] code, input bit ack, input bit clr);
        bit fd, psh, pp, drp;
        logic [4:0] pd;
        psh = 0; drp = 0; pd = code;
        if (m_win == SCAN - 1) begin
            fd = m_seen | hit;
            if (!m_level) begin
                if (fd) begin
                    m_streak++;
                    if (m_streak == DB) begin
                        m_level = 1; m_streak = 0; m_rep = 0;
                        psh = 1; m_code = code;
                    end
                end else m_streak = 0;
            end else if (!fd) begin
                m_streak++; m_rep = 0;
                if (m_streak == DB) begin m_level = 0; m_streak = 0; end
            end else if (m_streak > 0) begin
                m_streak = 0; m_rep = 0;
            end else begin
`ifdef KEY_REPEAT_EN
                m_rep++;
                if (m_rep == REP) begin m_rep = 0; psh = 1; pd = m_code; end
`endif
            end
            m_seen = 0; m_win = 0;
        end else begin
            m_seen = m_seen | hit;
            m_win++;
        end
        pp = (q.size() != 0) && ack;
        if (pp) void'(q.pop_front());
        if (psh) begin
            if (q.size() < DEPTH) q.push_back(pd);
            else drp = 1;
        end
        if (drp) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic m_compare();
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("key_down", 32'(key_down), 32'(m_level));
        if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            m_step(key_hit, key_code, rd_ack, ovf_clr);
            #1;
            if (rst_n) m_compare();
        end
    end

    // Each call supplies the inputs for exactly one rising edge.
    task automatic cyc(input bit hit, input logic [4:0] code, input bit ack, input bit clr);
        @(negedge clk);
        key_hit = hit; key_code = code; rd_ack = ack; ovf_clr = clr;
    endtask

    task automatic frames(input bit hit, input logic [4:0] code, input int n);
        repeat (n * SCAN) cyc(hit, code, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [4:0] code);
        frames(1'b1, code, DB);
        frames(1'b0, code, DB);
    endtask

    task automatic drain();
        repeat (3 * SCAN) cyc(1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic release_rst(input bit hit, input logic [4:0] code);
        @(negedge clk);
        rst_n = 1'b1; key_hit = hit; key_code = code; rd_ack = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic pop_expect(input logic [4:0] exp[8]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("pop_order", 32'(rd_data), 32'(exp[i]));
            key_hit = 1'b0; rd_ack = 1'b1; ovf_clr = 1'b0;
        end
        repeat (SCAN) cyc(1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("empty_valid", 32'(rd_valid), 32'd0);
        chk("empty_count", 32'(count), 32'd0);
    endtask

    logic [4:0] exp8[8];
    bit         lvl, hit;
    logic [4:0] rc;

    initial begin
        m_reset();
        #12;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_down", 32'(key_down), 32'd0);

        // Key 5 held from cycle 0: push on the cycle-11 edge.
        release_rst(1'b1, 5'd5);
        repeat (10) cyc(1'b1, 5'd5, 1'b0, 1'b0);
        settle();
        chk("t1_pre_valid", 32'(rd_valid), 32'd0);
        cyc(1'b1, 5'd5, 1'b0, 1'b0);
        settle();
        chk("t1_valid", 32'(rd_valid), 32'd1);
        chk("t1_data", 32'(rd_data), 32'd5);
        chk("t1_down", 32'(key_down), 32'd1);
        frames(1'b0, 5'd0, DB);
        drain();

        // Bounce, then a short release that must not re-trigger.
        frames(1'b1, 5'd9, 1);
        frames(1'b0, 5'd9, 1);
        frames(1'b1, 5'd9, 2);
        settle();
        chk("t2_none_yet", 32'(count), 32'd0);
        frames(1'b1, 5'd9, 1);
        settle();
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_data", 32'(rd_data), 32'd9);
        frames(1'b0, 5'd9, 2);
        frames(1'b1, 5'd9, 3);
        settle();
        chk("t2_no_second", 32'(count), 32'd1);
        frames(1'b0, 5'd0, DB);
        drain();

        // Fill, overflow, clear, ordered drain.
        for (int i = 0; i < 8; i++) press(5'(10 + i));
        settle();
        chk("t3_full", 32'(count), 32'd8);
        chk("t3_no_ovf", 32'(overflow), 32'd0);
        press(5'd20);
        settle();
        chk("t3_still8", 32'(count), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_head", 32'(rd_data), 32'd10);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);
        repeat (SCAN - 1) cyc(1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) exp8[i] = 5'(10 + i);
        pop_expect(exp8);

        // Full FIFO, pop on the same edge as the push.
        for (int i = 0; i < 8; i++) press(5'(30 + i));
        frames(1'b1, 5'd7, DB - 1);
        repeat (SCAN - 1) cyc(1'b1, 5'd7, 1'b0, 1'b0);
        cyc(1'b1, 5'd7, 1'b1, 1'b0);
        settle();
        chk("t4_count", 32'(count), 32'd8);
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_head", 32'(rd_data), 32'd31);
        frames(1'b0, 5'd0, DB);
        for (int i = 0; i < 7; i++) exp8[i] = 5'(31 + i);
        exp8[7] = 5'd7;
        pop_expect(exp8);

        // Async reset in the middle of press debounce.
        press(5'd3);
        frames(1'b1, 5'd4, 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t5_valid", 32'(rd_valid), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_down", 32'(key_down), 32'd0);
        release_rst(1'b1, 5'd4);
        repeat (SCAN - 1) cyc(1'b1, 5'd4, 1'b0, 1'b0);
        frames(1'b0, 5'd0, DB);
        settle();
        chk("t5_no_push", 32'(count), 32'd0);

        // Long hold of key 0.
        frames(1'b1, 5'd0, DB + 20);
        settle();
`ifdef KEY_REPEAT_EN
        chk("t6_events", 32'(count), 32'd6);
`else
        chk("t6_events", 32'(count), 32'd1);
`endif
        chk("t6_code", 32'(rd_data), 32'd0);
        frames(1'b0, 5'd0, DB);
        drain();

        // Randomized activity with in-window bounce, random pops and clears.
        lvl = 0;
        rc  = 5'd1;
        for (int w = 0; w < 600; w++) begin
            if ($urandom_range(0, 3) == 0) lvl = ~lvl;
            if ($urandom_range(0, 3) == 0) rc = 5'($urandom_range(0, 31));
            for (int c = 0; c < SCAN; c++) begin
                hit = ($urandom_range(0, 7) == 0) ? ~lvl : lvl;
                cyc(hit, rc, ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
            end
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
